conv_sequencer: RTL

- Control FSM that drives the convolution offset generator.
- Sequences the generator through three phases: filter load, line read with MAC, and result store.
- Drives `gen_active`/`gen_mode`, consumes `gen_done` and `gen_val`, and forms memory addresses as base + offset.
- Sits between the top-level start/finish handshake and the shared data memory / MAC datapath.

---
 rtl/conv_sequencer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/conv_sequencer.sv
// conv_sequencer: control FSM that walks the convolution offset generator
// through filter load, line read/MAC and result store phases.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             one-cycle run request, honoured only when idle
//   busy              high while in FILTER, LINE or STORE
//   finished          one-cycle pulse when a run completes
//   error             sticky; generator missed its done deadline
//   gen_active        enable to the offset generator
//   gen_mode          generator mode: 00 filter, 01 store, 10 line
//   gen_clr           generator clear, pulsed at the end of a run
//   gen_done          generator phase-complete flag
//   gen_val           current generator offset
//   mem_addr          memory address, phase base + gen_val
//   mem_rd, mem_wr    memory read/write strobes
//   mac_en, mac_clr   accumulate / clear controls for the MAC
module conv_sequencer #(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] FILTER_BASE = ADDR_W'(32'h0000_0000),
    parameter logic [ADDR_W-1:0] LINE_BASE   = ADDR_W'(32'h0000_0100),
    parameter logic [ADDR_W-1:0] OUT_BASE    = ADDR_W'(32'h0000_0200),
    parameter int                NUM_LINES   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              finished,
    output logic              error,
    output logic              gen_active,
    output logic [1:0]        gen_mode,
    output logic              gen_clr,
    input  logic              gen_done,
    input  logic [ADDR_W-1:0] gen_val,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              mac_en,
    output logic              mac_clr
);

    localparam int LW = $clog2(NUM_LINES) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILTER,
        S_LINE,
        S_STORE,
        S_FIN,
        S_ERR
    } state_t;

    state_t          r_state, w_next;
    logic [1:0]      r_step, w_step;
    logic [LW-1:0]   r_line, w_line;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_step  <= 2'd0;
            r_line  <= '0;
        end else begin
            r_state <= w_next;
            r_step  <= w_step;
            r_line  <= w_line;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_step     = r_step;
        w_line     = r_line;
        busy       = 1'b0;
        finished   = 1'b0;
        error      = 1'b0;
        gen_active = 1'b0;
        gen_mode   = 2'b00;
        gen_clr    = 1'b0;
        mem_addr   = '0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mac_en     = 1'b0;
        mac_clr    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_FILTER;
                    w_step = 2'd0;
                    w_line = '0;
                end
            end
            S_FILTER: begin
                busy       = 1'b1;
                gen_active = 1'b1;
                mem_rd     = 1'b1;
                mem_addr   = FILTER_BASE + gen_val;
                // The generator gets four cycles (step 0..3) to raise done
                if (gen_done) begin
                    w_next = S_LINE;
                    w_step = 2'd0;
                end else if (r_step == 2'd3) begin
                    w_next = S_ERR;
                end else begin
                    w_step = r_step + 2'd1;
                end
            end
            S_LINE: begin
                busy       = 1'b1;
                gen_active = 1'b1;
                gen_mode   = 2'b10;
                mem_rd     = 1'b1;
                mac_en     = 1'b1;
                mem_addr   = LINE_BASE + gen_val;
                if (gen_done) begin
                    w_next = S_STORE;
                    w_step = 2'd0;
                end else if (r_step == 2'd3) begin
                    w_next = S_ERR;
                end else begin
                    w_step = r_step + 2'd1;
                end
            end
            S_STORE: begin
                busy       = 1'b1;
                gen_active = 1'b1;
                gen_mode   = 2'b01;
                mem_wr     = 1'b1;
                mac_clr    = 1'b1;
                mem_addr   = OUT_BASE + gen_val;
                w_line     = r_line + 1'b1;
                w_next     = (r_line == LW'(NUM_LINES - 1)) ? S_FIN : S_LINE;
            end
            S_FIN: begin
                // Clearing here leaves the generator at offset 0 for the next run
                finished = 1'b1;
                gen_clr  = 1'b1;
                w_next   = S_IDLE;
            end
            S_ERR: begin
                error = 1'b1;
            end
            default: begin
                w_next = S_IDLE;
                w_step = 2'd0;
                w_line = '0;
            end
        endcase
    end

endmodule
